// File: rtl/opb_fifo_simulink2ppc.sv
// opb_fifo_simulink2ppc
//   The user logic pushes 32-bit words into an on-chip FIFO. The PowerPC
//   drains that FIFO through an OPB slave window.
//
//   Optional feature macro: OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
//     When defined, each entry carries a 32-bit free-running cycle stamp.
//     A DATA pop latches that stamp into TSTAMP (offset 0x08).
//
//   Ports
//     OPB_Clk, OPB_Rst        : clock and synchronous active-high reset
//     OPB_ABus/BE/DBus/RNW    : OPB master request (big-endian bit numbering)
//     OPB_select, OPB_seqAddr : transfer request; seqAddr is ignored
//     Sl_DBus, Sl_xferAck     : registered read data and one-cycle acknowledge
//     Sl_errAck/retry/toutSup : tied low
//     user_data_in/user_valid : user-side push port
//     user_full               : FIFO holds D entries
//
//   Register map (offset bits [3:2])
//     0x00 DATA   RO  pops the head word; reads 0 when the FIFO is empty
//     0x04 STATUS     {ovf, unf, 12'b0, full, empty, count[15:0]}; W1C on 31/30
//     0x08 TSTAMP RO  timestamp of the last popped word (0 if the feature is off)
//     0x0C        RO  reads 0
module opb_fifo_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR    = 32'h01100500,
  parameter logic [31:0] C_HIGHADDR    = 32'h011005FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter              C_FAMILY      = "virtex6",
  parameter int          C_FIFO_AWIDTH = 4
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_valid,
  output logic                      user_full
);

  localparam int unsigned AW = C_FIFO_AWIDTH;
  localparam int unsigned D  = 1 << AW;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

`ifdef OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
  localparam int unsigned EW = 64;
`else
  localparam int unsigned EW = 32;
`endif

  localparam bit FAMILY_SET = (C_FAMILY != "");

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_TSTAMP = 2'd2,
    REG_SPARE  = 2'd3
  } reg_sel_e;

  logic [31:0]   addr, offset, wdata, rdata;
  reg_sel_e      reg_sel;
  logic          hit, rd_data, pop, push, uflow_set, oflow_set;
  logic          w1c, clr_ovf, clr_unf;
  logic          empty, full;
  logic          overflow, underflow;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [EW-1:0] mem [D];
  logic [EW-1:0] head_word;
  logic          unused_ok;

`ifdef OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] tstamp;
`endif

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign addr    = OPB_ABus;
  assign wdata   = OPB_DBus;
  assign offset  = addr - C_BASEADDR;
  assign reg_sel = reg_sel_e'(offset[3:2]);

  // The ack guard keeps the cycle that shows the ack from being a new hit.
  assign hit = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR) && !Sl_xferAck;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign user_full = full;

  assign rd_data   = hit && OPB_RNW && (reg_sel == REG_DATA);
  assign pop       = rd_data && !empty;
  assign uflow_set = rd_data && empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push      = user_valid && (!full || pop);
  assign oflow_set = user_valid && full && !pop;

  assign w1c     = hit && !OPB_RNW && (reg_sel == REG_STATUS) && OPB_BE[0];
  assign clr_ovf = w1c && wdata[31];
  assign clr_unf = w1c && wdata[30];

  // Distributed-RAM style read so DATA returns one cycle after the hit.
  assign head_word = mem[head];

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DATA:   if (!empty) rdata = head_word[31:0];
      REG_STATUS: rdata = {overflow, underflow, 12'b0, full, empty, 16'(count)};
`ifdef OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
      REG_TSTAMP: rdata = tstamp;
`else
      REG_TSTAMP: rdata = '0;
`endif
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      Sl_xferAck <= 1'b0;
      Sl_DBus    <= '0;
    end else begin
      Sl_xferAck <= hit;
      Sl_DBus    <= (hit && OPB_RNW) ? rdata : '0;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (push) begin
`ifdef OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
      mem[tail] <= {ts_cnt, user_data_in};
`else
      mem[tail] <= user_data_in;
`endif
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop)  head <= head + AW'(1);
      if (push) tail <= tail + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A set event in the same cycle as its W1C wins.
      overflow  <= oflow_set | (overflow  & ~clr_ovf);
      underflow <= uflow_set | (underflow & ~clr_unf);
    end
  end

`ifdef OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (pop) tstamp <= head_word[63:32];
    end
  end
`endif

  assign unused_ok = ^{OPB_seqAddr, OPB_BE[1:C_OPB_DWIDTH/8-1], wdata[29:0],
                       offset[31:4], offset[1:0], FAMILY_SET};

endmodule

// File: tb/tb_opb_fifo_simulink2ppc.sv
// Scoreboard bench for opb_fifo_simulink2ppc (default D = 16).
// Expected DATA words are queued at push time and popped when a DATA read
// acknowledges; STATUS/TSTAMP expectations are constants derived from the
// register map.
module tb_opb_fifo_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01100500;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw, sel, seq;
  logic [0:31] sl_dbus;
  logic        ack, err_ack, retry, tout_sup;
  logic [31:0] udata;
  logic        uvalid;
  logic        ufull;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  opb_fifo_simulink2ppc #(
    .C_BASEADDR   (32'h01100500),
    .C_HIGHADDR   (32'h011005FF),
    .C_FIFO_AWIDTH(4)
  ) dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (rst),
    .OPB_ABus    (abus),
    .OPB_BE      (be),
    .OPB_DBus    (dbus),
    .OPB_RNW     (rnw),
    .OPB_select  (sel),
    .OPB_seqAddr (seq),
    .Sl_DBus     (sl_dbus),
    .Sl_xferAck  (ack),
    .Sl_errAck   (err_ack),
    .Sl_retry    (retry),
    .Sl_toutSup  (tout_sup),
    .user_data_in(udata),
    .user_valid  (uvalid),
    .user_full   (ufull)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Hit in one cycle, ack checked in the next, idle bus checked after that.
  task automatic bus_op(input logic rnw_i, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be_i, input logic push_i, input logic [31:0] pd,
                        input logic [31:0] exp, input string tag);
    @(negedge clk);
    sel = 1'b1; rnw = rnw_i; abus = a; dbus = wd; be = be_i;
    uvalid = push_i; udata = pd;
    @(posedge clk); #1;
    uvalid = 1'b0;
    check({tag, "_ack"}, {31'b0, ack}, 32'd1);
    if (rnw_i) check(tag, sl_dbus, exp);
    @(negedge clk);
    sel = 1'b0; rnw = 1'b0; dbus = '0; be = '0;
    @(posedge clk); #1;
    check({tag, "_ack_low"}, {31'b0, ack}, 32'd0);
    check({tag, "_dbus_idle"}, sl_dbus, 32'd0);
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    uvalid = 1'b1; udata = d;
    @(posedge clk); #1;
    uvalid = 1'b0;
    if (exp_q.size() < 16) exp_q.push_back(d);
  endtask

  task automatic pop_data(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    bus_op(1'b1, BASE, '0, 4'hF, 1'b0, '0, e, tag);
  endtask

  task automatic read_status(input logic [31:0] exp, input string tag);
    bus_op(1'b1, BASE + 32'h4, '0, 4'hF, 1'b0, '0, exp, tag);
  endtask

  task automatic write_status(input logic [31:0] wd, input logic [3:0] be_i);
    bus_op(1'b0, BASE + 32'h4, wd, be_i, 1'b0, '0, '0, "w1c");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    udata = '0; uvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    check("rst_full", {31'b0, ufull}, 32'd0);
    check("tied_low", {29'b0, err_ack, retry, tout_sup}, 32'd0);
    read_status(32'h00010000, "status_reset");

    for (int unsigned i = 1; i <= 3; i++) push_word(32'hA5A50000 + i);
    for (int unsigned i = 0; i < 3; i++) pop_data("data_in_order");
    read_status(32'h00010000, "status_drained");

    for (int unsigned i = 0; i < 17; i++) begin
      push_word(32'hC0DE0000 + i);
      if (i == 15) check("full_after_16", {31'b0, ufull}, 32'd1);
    end
    check("full_after_17", {31'b0, ufull}, 32'd1);
    read_status(32'h80020010, "status_overflow");
    write_status(32'h80000000, 4'b0000);
    read_status(32'h80020010, "w1c_be_off");
    write_status(32'h80000000, 4'b1000);
    read_status(32'h00020010, "w1c_be_on");

    e = exp_q.pop_front();
    exp_q.push_back(32'hBEEF0001);
    bus_op(1'b1, BASE, '0, 4'hF, 1'b1, 32'hBEEF0001, e, "pop_push_full");
    read_status(32'h00020010, "status_pop_push_full");
    for (int unsigned i = 0; i < 16; i++) pop_data("drain_full");
    check("full_cleared", {31'b0, ufull}, 32'd0);

    bus_op(1'b1, BASE, '0, 4'hF, 1'b0, '0, 32'd0, "empty_read");
    read_status(32'h40010000, "status_underflow");
    write_status(32'h40000000, 4'b1000);
    read_status(32'h00010000, "status_unf_clear");

    bus_op(1'b1, BASE, '0, 4'hF, 1'b1, 32'h5555AAAA, 32'd0, "empty_read_push");
    exp_q.push_back(32'h5555AAAA);
    read_status(32'h40000001, "status_empty_push");
    pop_data("data_after_empty_push");
    write_status(32'hC0000000, 4'b1000);

    for (int unsigned i = 0; i < 5; i++) push_word(32'h11110000 + i);
    for (int unsigned i = 0; i < 40; i++) begin
      e = exp_q.pop_front();
      exp_q.push_back(32'h22220000 + i);
      bus_op(1'b1, BASE, '0, 4'hF, 1'b1, 32'h22220000 + i, e, "wrap_data");
    end
    read_status(32'h00000005, "status_wrap");
    for (int unsigned i = 0; i < 5; i++) pop_data("wrap_drain");

    bus_op(1'b1, BASE + 32'hC, '0, 4'hF, 1'b0, '0, 32'd0, "spare_read");
    bus_op(1'b0, BASE + 32'hC, 32'hFFFFFFFF, 4'hF, 1'b0, '0, '0, "spare_write");
    read_status(32'h00010000, "status_after_spare");

    for (int unsigned i = 0; i < 3; i++) push_word(32'h33330000 + i);
    @(negedge clk);
    sel = 1'b1; rnw = 1'b1; abus = BASE; be = 4'hF; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_ack", {31'b0, ack}, 32'd0);
    check("rst_mid_dbus", sl_dbus, 32'd0);
    @(negedge clk);
    sel = 1'b0; rnw = 1'b0; rst = 1'b0;
    exp_q.delete();

`ifdef OPB_FIFO_SIMULINK2PPC_TSTAMP_EN
    // Counter reads k during the cycle after the k-th post-reset edge.
    repeat (10) @(posedge clk);
    push_word(32'h7777000A);
    repeat (14) @(posedge clk);
    push_word(32'h77770019);
    pop_data("ts_data0");
    bus_op(1'b1, BASE + 32'h8, '0, 4'hF, 1'b0, '0, 32'd10, "tstamp_first");
    pop_data("ts_data1");
    bus_op(1'b1, BASE + 32'h8, '0, 4'hF, 1'b0, '0, 32'd25, "tstamp_second");
    bus_op(1'b1, BASE, '0, 4'hF, 1'b0, '0, 32'd0, "ts_empty_read");
    bus_op(1'b1, BASE + 32'h8, '0, 4'hF, 1'b0, '0, 32'd25, "tstamp_hold");
    write_status(32'h40000000, 4'b1000);
`else
    bus_op(1'b1, BASE + 32'h8, '0, 4'hF, 1'b0, '0, 32'd0, "tstamp_off");
`endif
    read_status(32'h00010000, "status_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
